memoria_dados_lat: RTL and testbench

Parametrised successor to the 8-bit nRisc data memory. Storage width, depth and read latency are configurable. Adds a read-valid/busy handshake, an out-of-range address flag and a read/write conflict flag. Sits between nRisc (Endereco, EscreveDado, MemWrite, MemRead, LeDado) and the storage array, so the processor can stall on multi-cycle reads.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/memoria_nucleo.sv | 33 +++
 rtl/memoria_dados_lat.sv | 120 ++++++++++++
 tb/tb_memoria_dados_lat.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
// Module : mem_pkg
// Brief  : Shared FSM states and latency-counter sizing for memoria_dados_lat.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      LENDO   = 2'd1,
      ENTREGA = 2'd2
   } estado_t;

   localparam int LAT_MAX = 4;
   localparam int CNT_W   = $clog2(LAT_MAX + 1);

endpackage

`default_nettype wire

// File: rtl/memoria_nucleo.sv
// ============================================================================
// Module : memoria_nucleo
// Brief  : DATA_W x DEPTH storage, synchronous write, combinational read, no reset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module memoria_nucleo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256,
   parameter int IDX_W  = 8
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [IDX_W-1:0]  raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/memoria_dados_lat.sv
// ============================================================================
// Module : memoria_dados_lat
// Brief  : nRisc data memory with configurable read latency, busy/valid
//          handshake, out-of-range and read/write conflict pulses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module memoria_dados_lat
   import mem_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int DEPTH    = 256,
   parameter int READ_LAT = 1
) (
   input  logic              Clock,
   input  logic              reset,
   input  logic              MemWrite,
   input  logic              MemRead,
   input  logic [ADDR_W-1:0] Endereco,
   input  logic [DATA_W-1:0] EscreveDado,
   output logic [DATA_W-1:0] LeDado,
   output logic              LeValido,
   output logic              Ocupado,
   output logic              ErroEnd,
   output logic              Conflito
);

   localparam int              c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] c_DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   estado_t            state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [c_IDX_W-1:0] addr_q;
   logic               oor_q;
   logic [DATA_W-1:0]  LeDado_q;
   logic               LeValido_q;
   logic               ErroEnd_q;
   logic               Conflito_q;

   logic               w_oor;
   logic               w_idle;
   logic               w_we;
   logic [DATA_W-1:0]  w_rdata;

   // Zero-extended compare keeps the test unsigned and exact when DEPTH == 2**ADDR_W.
   assign w_oor  = ({1'b0, Endereco} >= c_DEPTH_EXT);
   assign w_idle = (state_q == OCIOSO);
   assign w_we   = w_idle & MemWrite & ~w_oor;

   memoria_nucleo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (c_IDX_W)
   ) u_nucleo (
      .clk_i   (Clock),
      .we_i    (w_we),
      .waddr_i (Endereco[c_IDX_W-1:0]),
      .wdata_i (EscreveDado),
      .raddr_i (addr_q),
      .rdata_o (w_rdata)
   );

   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         state_q    <= OCIOSO;
         cnt_q      <= '0;
         addr_q     <= '0;
         oor_q      <= 1'b0;
         LeDado_q   <= '0;
         LeValido_q <= 1'b0;
         ErroEnd_q  <= 1'b0;
         Conflito_q <= 1'b0;
      end else begin
         LeValido_q <= 1'b0;
         ErroEnd_q  <= 1'b0;
         Conflito_q <= 1'b0;
         case (state_q)
            OCIOSO: begin
               if (MemWrite) begin
                  ErroEnd_q  <= w_oor;
                  Conflito_q <= MemRead;
               end else if (MemRead) begin
                  addr_q <= Endereco[c_IDX_W-1:0];
                  oor_q  <= w_oor;
                  if (READ_LAT == 1) begin
                     state_q <= ENTREGA;
                  end else begin
                     state_q <= LENDO;
                     cnt_q   <= CNT_W'(READ_LAT - 1);
                  end
               end
            end
            LENDO: begin
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= ENTREGA;
               end
            end
            ENTREGA: begin
               LeValido_q <= 1'b1;
               ErroEnd_q  <= oor_q;
               LeDado_q   <= oor_q ? '0 : w_rdata;
               state_q    <= OCIOSO;
            end
            default: state_q <= OCIOSO;
         endcase
      end
   end

   assign LeDado   = LeDado_q;
   assign LeValido = LeValido_q;
   assign Ocupado  = (state_q != OCIOSO);
   assign ErroEnd  = ErroEnd_q;
   assign Conflito = Conflito_q;

endmodule

`default_nettype wire

// File: tb/tb_memoria_dados_lat.sv
// ============================================================================
// Module : tb_memoria_dados_lat
// Brief  : Self-checking bench; instance k has READ_LAT=k+1 (k=0: DEPTH 256, else 200).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_memoria_dados_lat;

   typedef struct {
      int         k;
      logic       mw;
      logic       mr;
      logic [7:0] a;
      logic [7:0] d;
      logic       lv;
      logic       oc;
      logic       ee;
      logic       cf;
      logic [7:0] ld;
   } vec_t;

   logic       clk;
   logic       rst_n [4];
   logic       mw    [4];
   logic       mr    [4];
   logic [7:0] ad    [4];
   logic [7:0] wd    [4];
   logic [7:0] ld    [4];
   logic       lv    [4];
   logic       oc    [4];
   logic       ee    [4];
   logic       cf    [4];

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   generate
      for (genvar k = 0; k < 4; k++) begin : g_dut
         memoria_dados_lat #(
            .DATA_W   (8),
            .ADDR_W   (8),
            .DEPTH    ((k == 0) ? 256 : 200),
            .READ_LAT (k + 1)
         ) u_dut (
            .Clock       (clk),
            .reset       (rst_n[k]),
            .MemWrite    (mw[k]),
            .MemRead     (mr[k]),
            .Endereco    (ad[k]),
            .EscreveDado (wd[k]),
            .LeDado      (ld[k]),
            .LeValido    (lv[k]),
            .Ocupado     (oc[k]),
            .ErroEnd     (ee[k]),
            .Conflito    (cf[k])
         );
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s dut=%0d actual=%h expected=%h", name, k, act, exp_v);
      end
   endtask

   task automatic set_in(input int k, input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
      for (int j = 0; j < 4; j++) begin
         mw[j] = 1'b0;
         mr[j] = 1'b0;
         ad[j] = 8'h00;
         wd[j] = 8'h00;
      end
      mw[k] = w;
      mr[k] = r;
      ad[k] = a;
      wd[k] = d;
   endtask

   task automatic wr(input int k, input logic [7:0] a, input logic [7:0] d);
      set_in(k, 1'b1, 1'b0, a, d);
      @(negedge clk);
      set_in(k, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   // Busy for READ_LAT cycles after acceptance, then one valid cycle with the data.
   task automatic lat_check(input int k, input logic [7:0] a, input logic [7:0] expd);
      int lat;
      lat = k + 1;
      set_in(k, 1'b0, 1'b1, a, 8'h00);
      for (int i = 1; i <= lat + 1; i++) begin
         @(negedge clk);
         if (i == 1) set_in(k, 1'b0, 1'b0, 8'h00, 8'h00);
         chk($sformatf("lat_busy_c%0d", i), k, {7'd0, oc[k]}, {7'd0, (i <= lat)});
         chk($sformatf("lat_valid_c%0d", i), k, {7'd0, lv[k]}, {7'd0, (i == lat + 1)});
      end
      chk("lat_data", k, ld[k], expd);
      @(negedge clk);
      chk("lat_valid_drop", k, {7'd0, lv[k]}, 8'h00);
   endtask

   function automatic vec_t mk(int k, logic w, logic r, logic [7:0] a, logic [7:0] d,
                               logic v, logic o, logic e, logic c, logic [7:0] q);
      vec_t t;
      t.k = k; t.mw = w; t.mr = r; t.a = a; t.d = d;
      t.lv = v; t.oc = o; t.ee = e; t.cf = c; t.ld = q;
      return t;
   endfunction

   initial begin
      int npulse;
      int nflag;

      // instance 0: READ_LAT=1, DEPTH=256
      vecs.push_back(mk(0, 0, 0, 8'd0,   8'h00, 0, 0, 0, 0, 8'h00));
      vecs.push_back(mk(0, 1, 0, 8'd3,   8'hA5, 0, 0, 0, 0, 8'h00));
      vecs.push_back(mk(0, 0, 1, 8'd3,   8'h00, 0, 1, 0, 0, 8'h00));
      vecs.push_back(mk(0, 0, 0, 8'd0,   8'h00, 1, 0, 0, 0, 8'hA5));
      vecs.push_back(mk(0, 0, 0, 8'd0,   8'h00, 0, 0, 0, 0, 8'hA5));
      vecs.push_back(mk(0, 1, 1, 8'd5,   8'h77, 0, 0, 0, 1, 8'hA5));
      vecs.push_back(mk(0, 0, 0, 8'd0,   8'h00, 0, 0, 0, 0, 8'hA5));
      vecs.push_back(mk(0, 0, 1, 8'd5,   8'h00, 0, 1, 0, 0, 8'hA5));
      vecs.push_back(mk(0, 0, 0, 8'd0,   8'h00, 1, 0, 0, 0, 8'h77));
      vecs.push_back(mk(0, 1, 0, 8'd10,  8'h3C, 0, 0, 0, 0, 8'h77));
      vecs.push_back(mk(0, 0, 1, 8'd10,  8'h00, 0, 1, 0, 0, 8'h77));
      vecs.push_back(mk(0, 0, 1, 8'd3,   8'h00, 1, 0, 0, 0, 8'h3C));
      vecs.push_back(mk(0, 0, 0, 8'd0,   8'h00, 0, 0, 0, 0, 8'h3C));
      vecs.push_back(mk(0, 1, 0, 8'd255, 8'h99, 0, 0, 0, 0, 8'h3C));
      vecs.push_back(mk(0, 0, 1, 8'd255, 8'h00, 0, 1, 0, 0, 8'h3C));
      vecs.push_back(mk(0, 0, 0, 8'd0,   8'h00, 1, 0, 0, 0, 8'h99));
      vecs.push_back(mk(0, 1, 0, 8'd7,   8'h42, 0, 0, 0, 0, 8'h99));
      vecs.push_back(mk(0, 0, 1, 8'd7,   8'h00, 0, 1, 0, 0, 8'h99));
      vecs.push_back(mk(0, 0, 0, 8'd0,   8'h00, 1, 0, 0, 0, 8'h42));
      // instance 1: READ_LAT=2, DEPTH=200
      vecs.push_back(mk(1, 1, 0, 8'd210, 8'h55, 0, 0, 1, 0, 8'h00));
      vecs.push_back(mk(1, 0, 0, 8'd0,   8'h00, 0, 0, 0, 0, 8'h00));
      vecs.push_back(mk(1, 0, 1, 8'd210, 8'h00, 0, 1, 0, 0, 8'h00));
      vecs.push_back(mk(1, 0, 0, 8'd0,   8'h00, 0, 1, 0, 0, 8'h00));
      vecs.push_back(mk(1, 0, 0, 8'd0,   8'h00, 1, 0, 1, 0, 8'h00));
      vecs.push_back(mk(1, 1, 0, 8'd199, 8'h66, 0, 0, 0, 0, 8'h00));
      vecs.push_back(mk(1, 0, 1, 8'd199, 8'h00, 0, 1, 0, 0, 8'h00));
      vecs.push_back(mk(1, 0, 0, 8'd0,   8'h00, 0, 1, 0, 0, 8'h00));
      vecs.push_back(mk(1, 0, 0, 8'd0,   8'h00, 1, 0, 0, 0, 8'h66));

      // Reset / defaults
      for (int j = 0; j < 4; j++) rst_n[j] = 1'b0;
      set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      for (int j = 0; j < 4; j++) rst_n[j] = 1'b1;
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
         chk("rst_ld", j, ld[j], 8'h00);
         chk("rst_lv", j, {7'd0, lv[j]}, 8'h00);
         chk("rst_oc", j, {7'd0, oc[j]}, 8'h00);
         chk("rst_ee", j, {7'd0, ee[j]}, 8'h00);
         chk("rst_cf", j, {7'd0, cf[j]}, 8'h00);
      end

      // Cycle-accurate vector table
      foreach (vecs[i]) begin
         set_in(vecs[i].k, vecs[i].mw, vecs[i].mr, vecs[i].a, vecs[i].d);
         @(negedge clk);
         chk($sformatf("row%0d_lv", i), vecs[i].k, {7'd0, lv[vecs[i].k]}, {7'd0, vecs[i].lv});
         chk($sformatf("row%0d_oc", i), vecs[i].k, {7'd0, oc[vecs[i].k]}, {7'd0, vecs[i].oc});
         chk($sformatf("row%0d_ee", i), vecs[i].k, {7'd0, ee[vecs[i].k]}, {7'd0, vecs[i].ee});
         chk($sformatf("row%0d_cf", i), vecs[i].k, {7'd0, cf[vecs[i].k]}, {7'd0, vecs[i].cf});
         chk($sformatf("row%0d_ld", i), vecs[i].k, ld[vecs[i].k], vecs[i].ld);
      end
      set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);

      // Latency sweep over READ_LAT = 1..4
      for (int k = 0; k < 4; k++) begin
         wr(k, 8'd10, 8'h3C);
         lat_check(k, 8'd10, 8'h3C);
      end

      // Busy lockout on READ_LAT=3: write and reads during Ocupado are dropped
      wr(2, 8'd1, 8'h11);
      wr(2, 8'd2, 8'h22);
      set_in(2, 1'b0, 1'b1, 8'd1, 8'h00);
      npulse = 0;
      nflag  = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (lv[2]) begin
            npulse++;
            chk("busy_data", 2, ld[2], 8'h11);
         end
         if (ee[2] || cf[2]) nflag++;
         case (i)
            1:       set_in(2, 1'b1, 1'b0, 8'd1, 8'hFF);
            2:       set_in(2, 1'b0, 1'b1, 8'd2, 8'h00);
            3:       set_in(2, 1'b1, 1'b1, 8'd1, 8'hFF);
            default: set_in(2, 1'b0, 1'b0, 8'h00, 8'h00);
         endcase
      end
      chk("busy_pulses", 2, 8'(npulse), 8'd1);
      chk("busy_flags", 2, 8'(nflag), 8'd0);
      lat_check(2, 8'd1, 8'h11);

      // Asynchronous reset two cycles into LENDO on READ_LAT=4
      wr(3, 8'd20, 8'h5A);
      set_in(3, 1'b0, 1'b1, 8'd20, 8'h00);
      @(negedge clk);
      set_in(3, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      chk("mid_busy_before", 3, {7'd0, oc[3]}, 8'h01);
      #2 rst_n[3] = 1'b0;
      #1 chk("mid_busy_drop", 3, {7'd0, oc[3]}, 8'h00);
      @(negedge clk);
      rst_n[3] = 1'b1;
      npulse = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (lv[3]) npulse++;
      end
      chk("mid_no_valid", 3, 8'(npulse), 8'd0);
      chk("mid_ld_cleared", 3, ld[3], 8'h00);
      lat_check(3, 8'd20, 8'h5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
